// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bundle for the iterative divider.
// The divider takes the slave modport; the requester drives the master modport.
interface seq_divider_if #(
    parameter int DIVIDEND_W = 4,
    parameter int DIVISOR_W  = 2
) ();
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  ready;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  ready, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider, one quotient bit per clock.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iterations entirely.
module seq_divider #(
    parameter int DIVIDEND_W = 4,
    parameter int DIVISOR_W  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);
    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e                state_q,     state_d;
    logic [DIVISOR_W:0]    rem_q,       rem_d;
    logic [DIVIDEND_W-1:0] shreg_q,     shreg_d;
    logic [DIVISOR_W-1:0]  dsr_q,       dsr_d;
    logic [CNT_W-1:0]      count_q,     count_d;
    logic                  ready_q,     ready_d;
    logic                  done_q,      done_d;
    logic [DIVIDEND_W-1:0] quotient_q,  quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
    logic                  dbz_q,       dbz_d;

    logic [DIVISOR_W:0]    rem_shift;
    logic                  accept;
    logic                  dsr_zero;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        rem_d       = rem_q;
        shreg_d     = shreg_q;
        dsr_d       = dsr_q;
        count_d     = count_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        rem_shift = {rem_q[DIVISOR_W-1:0], shreg_q[DIVIDEND_W-1]};
        accept    = bus.start && (state_q != BUSY);
        dsr_zero  = (dsr_q == '0);

        // Results publish on leaving DONE, before a back-to-back accept overwrites the datapath.
        if (state_q == DONE) begin
            done_d      = 1'b1;
            quotient_d  = dsr_zero ? '1 : shreg_q;
            remainder_d = dsr_zero ? '0 : rem_q[DIVISOR_W-1:0];
            dbz_d       = dsr_zero;
        end

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    shreg_d = bus.dividend;
                    dsr_d   = bus.divisor;
                    rem_d   = '0;
                    count_d = CNT_W'(DIVIDEND_W);
                    state_d = BUSY;
`ifdef DIV_ZERO_FAST_EN
                    if (bus.divisor == '0) state_d = DONE;
`endif
                end
            end
            BUSY: begin
                // The dividend drains out of the top of shreg while quotient bits fill the bottom.
                if (rem_shift >= {1'b0, dsr_q}) begin
                    rem_d   = rem_shift - {1'b0, dsr_q};
                    shreg_d = {shreg_q[DIVIDEND_W-2:0], 1'b1};
                end else begin
                    rem_d   = rem_shift;
                    shreg_d = {shreg_q[DIVIDEND_W-2:0], 1'b0};
                end
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d != BUSY);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            shreg_q     <= '0;
            dsr_q       <= '0;
            count_q     <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            shreg_q     <= shreg_d;
            dsr_q       <= dsr_d;
            count_q     <= count_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.ready       = ready_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule
